i2c_bus_scheduler: RTL and testbench
====================================

// Module: i2c_bus_scheduler
// PURPOSE
//   Shares the single on-chip I2C master (which drives the sda/scl bidirectional pads) among NREQ sensor/actuator requesters.
//   - Round-robin arbitration; one I2C transaction at a time.
//   - Latches the winner's command, issues it to the master, waits for completion and returns the result to that requester only.
//   - Sits between the sensor-poll logic and the I2C master inside main.
// PARAMETERS
//   NREQ            4       number of requesters (2..8)
//   TIMEOUT_CYCLES  100000  WAIT-state watchdog limit in clk cycles (used only with I2C_SCHED_TIMEOUT_EN)
//   TW              17      watchdog counter width; must satisfy 2**TW > TIMEOUT_CYCLES
// PORTS
//   clk        in   1        system clock
//   rst        in   1        asynchronous, active-high reset
//   req        in   NREQ     per-requester transaction request (level)
//   req_rw     in   NREQ     per-requester direction: 1 = read, 0 = write
//   req_addr   in   NREQ*7   per-requester 7-bit slave address; requester i occupies [7i+6:7i]
//   req_reg    in   NREQ*8   per-requester register pointer; requester i occupies [8i+7:8i]
//   req_wdata  in   NREQ*8   per-requester write byte; requester i occupies [8i+7:8i]
//   grant      out  NREQ     one-hot; owner of the current transaction
//   done       out  NREQ     one-cycle completion pulse to the owner
//   rdata      out  8        read byte; valid only in the done cycle
//   err        out  1        NACK or timeout; valid only in the done cycle
//   sched_busy out  1        high whenever state != IDLE
//   m_start    out  1        one-cycle command strobe to the I2C master
//   m_rw       out  1        latched direction
//   m_addr     out  7        latched slave address
//   m_reg      out  8        latched register pointer
//   m_wdata    out  8        latched write byte
//   m_abort    out  1        one-cycle abort to the master (timeout only)
//   m_busy     in   1        master engaged on a transaction
//   m_done     in   1        master completion pulse
//   m_rdata    in   8        master read byte, valid with m_done
//   m_nack     in   1        slave NACK seen, valid with m_done
// BEHAVIOUR
//   Reset: state = IDLE; last_grant = NREQ-1, so requester 0 wins first.
//     - Every output and every latched field is 0.
//   FSM states: IDLE, ISSUE, WAIT, DONE.
//   IDLE
//     - If any req bit is set: pick the first set bit searching upward (with wrap) from last_grant+1.
//     - Latch that requester's rw/addr/reg/wdata, set its grant bit, go to ISSUE.
//   ISSUE
//     - While m_busy = 1: hold, with m_start = 0.
//     - When m_busy = 0: pulse m_start for exactly one cycle, go to WAIT.
//   WAIT
//     - On m_done: capture m_rdata and m_nack, go to DONE.
//   DONE
//     - done[owner] = 1, rdata = captured byte, err = captured nack (or timeout flag).
//     - last_grant <= owner; clear grant; go to IDLE.
//   Output timing
//     - grant is held from ISSUE through DONE.
//     - m_* command fields hold their values until the next latch.
//   Latency: req sampled in IDLE -> m_start 1 cycle later (m_busy = 0) -> done 1 cycle after m_done.
//   Handshake: the requester clears req on the edge where done is sampled high, so req is not re-granted spuriously.
//   Boundary conditions
//     - Dropping req after grant is ignored: the transaction completes and done still pulses.
//     - m_done arriving in the same cycle m_start is issued is ignored; m_done is honoured only in WAIT.
//     - Simultaneous requests: round-robin guarantees each of NREQ requesters is served within NREQ transactions.
//     - rst mid-transaction: immediate return to reset state; m_abort is not pulsed.
// CONFIGURATION
//   I2C_SCHED_TIMEOUT_EN defined
//     - A TW-bit counter clears on entry to WAIT and increments each WAIT cycle.
//     - If it reaches TIMEOUT_CYCLES-1 with no m_done: pulse m_abort one cycle, force err = 1 and rdata = 0, go to DONE.
//   Not defined: no counter and no m_abort logic (m_abort tied 0); WAIT waits for m_done indefinitely.
// STRUCTURE
//   Shared package i2c_sched_pkg
//     - state encoding constants (IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3)
//     - I2C_ADDR_W = 7, I2C_DATA_W = 8
//   One sub-module: rr_pick (combinational round-robin selector).
//     - Inputs: req and last_grant. Outputs: one-hot winner and its index.
// TESTING
//   1. req[0] read, addr 0x48, reg 0x00 -> one m_start with m_addr 0x48 and m_rw 1; master m_done with m_rdata 0xA5
//      -> done[0] for 1 cycle, rdata 0xA5, err 0.
//   2. After reset, req = 4'b1111 held (each requester clears on its done) -> grant order 0,1,2,3, never two done pulses in one cycle.
//   3. last_grant = 1, req = 4'b0110 -> requester 2 is served before 1.
//   4. req[3] write 0x5C to reg 0x10 with m_nack = 1 -> done[3] pulse, err 1; m_wdata 0x5C was presented at m_start.
//   5. TIMEOUT_CYCLES = 16, master never sends m_done.
//      - Macro defined: m_abort after 16 WAIT cycles, done with err 1, rdata 0x00.
//      - Macro undefined: sched_busy stays 1.
//   6. rst asserted while in WAIT -> all outputs 0 in the same cycle; after release, with req = 4'b1001, requester 0 is served first.

Source files
------------

// File: rtl/i2c_sched_pkg.sv
// Shared types and constants for the I2C bus scheduler.
package i2c_sched_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set req bit searching upward
// (with wrap) from last_grant+1.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] winner,
    output logic [IW-1:0]   idx
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        // NOTE: every output gets a default first so no path through the loop infers a latch.
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_grant) + k) % NREQ);
            if (!found && req[cand]) begin
                found        = 1'b1;
                winner[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_scheduler.sv
// Round-robin scheduler sharing one I2C master among NREQ requesters.
// Optional WAIT-state watchdog with m_abort: define I2C_SCHED_TIMEOUT_EN.
module i2c_bus_scheduler
    import i2c_sched_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TW             = 17
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_rw,
    input  logic [NREQ*7-1:0]      req_addr,
    input  logic [NREQ*8-1:0]      req_reg,
    input  logic [NREQ*8-1:0]      req_wdata,
    output logic [NREQ-1:0]        grant,
    output logic [NREQ-1:0]        done,
    output logic [7:0]             rdata,
    output logic                   err,
    output logic                   sched_busy,
    output logic                   m_start,
    output logic                   m_rw,
    output logic [6:0]             m_addr,
    output logic [7:0]             m_reg,
    output logic [7:0]             m_wdata,
    output logic                   m_abort,
    input  logic                   m_busy,
    input  logic                   m_done,
    input  logic [7:0]             m_rdata,
    input  logic                   m_nack
);

    localparam int IW = $clog2(NREQ);

    sched_state_t    state;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   owner;
    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
        .req        (req),
        .last_grant (last_grant),
        .winner     (pick_onehot),
        .idx        (pick_idx)
    );

    assign sched_busy = (state != IDLE);

    // Present in the hierarchy only when TW is too narrow to reach TIMEOUT_CYCLES-1.
    if (TIMEOUT_CYCLES >= (1 << TW)) begin : g_tw_too_narrow
    end

`ifdef I2C_SCHED_TIMEOUT_EN
    logic [TW-1:0] wd_cnt;
`else
    assign m_abort = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IW'(NREQ - 1);
            owner      <= '0;
            grant      <= '0;
            done       <= '0;
            rdata      <= '0;
            err        <= 1'b0;
            m_start    <= 1'b0;
            m_rw       <= 1'b0;
            m_addr     <= '0;
            m_reg      <= '0;
            m_wdata    <= '0;
`ifdef I2C_SCHED_TIMEOUT_EN
            m_abort    <= 1'b0;
            wd_cnt     <= '0;
`endif
        end else begin
            // NOTE: strobes default low here so each is a single-cycle pulse.
            done    <= '0;
            m_start <= 1'b0;
`ifdef I2C_SCHED_TIMEOUT_EN
            m_abort <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner   <= pick_idx;
                        grant   <= pick_onehot;
                        m_rw    <= req_rw[pick_idx];
                        m_addr  <= req_addr[pick_idx*I2C_ADDR_W +: I2C_ADDR_W];
                        m_reg   <= req_reg[pick_idx*I2C_DATA_W +: I2C_DATA_W];
                        m_wdata <= req_wdata[pick_idx*I2C_DATA_W +: I2C_DATA_W];
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!m_busy) begin
                        m_start <= 1'b1;
                        state   <= WAIT;
`ifdef I2C_SCHED_TIMEOUT_EN
                        wd_cnt  <= '0;
`endif
                    end
                end
                WAIT: begin
                    // m_done coincident with our own m_start belongs to an earlier transfer.
                    if (m_done && !m_start) begin
                        done[owner] <= 1'b1;
                        rdata       <= m_rdata;
                        err         <= m_nack;
                        state       <= DONE;
                    end
`ifdef I2C_SCHED_TIMEOUT_EN
                    else if (wd_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        m_abort     <= 1'b1;
                        done[owner] <= 1'b1;
                        rdata       <= '0;
                        err         <= 1'b1;
                        state       <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    last_grant <= owner;
                    grant      <= '0;
                    rdata      <= '0;
                    err        <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_bus_scheduler.sv
// Scoreboard bench for i2c_bus_scheduler; covers both I2C_SCHED_TIMEOUT_EN builds.
module tb_i2c_bus_scheduler;

    localparam int NREQ = 4;
    localparam int TO   = 16;

    typedef struct { logic [NREQ-1:0] done_vec; logic [7:0] rdata; logic err; } exp_done_t;
    typedef struct { logic rw; logic [6:0] addr; logic [7:0] ptr; logic [7:0] wdata; } exp_cmd_t;
    typedef struct { logic [7:0] rdata; logic nack; int delay; logic early; logic hang; } resp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   req_rw = '0;
    logic [NREQ*7-1:0] req_addr = '0;
    logic [NREQ*8-1:0] req_reg = '0;
    logic [NREQ*8-1:0] req_wdata = '0;
    logic [NREQ-1:0]   grant, done;
    logic [7:0]        rdata;
    logic              err, sched_busy, m_start, m_rw, m_abort;
    logic [6:0]        m_addr;
    logic [7:0]        m_reg, m_wdata;
    logic              m_busy = 1'b0;
    logic              m_done = 1'b0;
    logic [7:0]        m_rdata = '0;
    logic              m_nack = 1'b0;

    exp_done_t done_q[$];
    exp_cmd_t  cmd_q[$];
    resp_t     resp_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int abort_cnt = 0;
    logic [NREQ-1:0] prev_done = '0;

    i2c_bus_scheduler #(.NREQ(NREQ), .TIMEOUT_CYCLES(TO), .TW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_rw     (req_rw),
        .req_addr   (req_addr),
        .req_reg    (req_reg),
        .req_wdata  (req_wdata),
        .grant      (grant),
        .done       (done),
        .rdata      (rdata),
        .err        (err),
        .sched_busy (sched_busy),
        .m_start    (m_start),
        .m_rw       (m_rw),
        .m_addr     (m_addr),
        .m_reg      (m_reg),
        .m_wdata    (m_wdata),
        .m_abort    (m_abort),
        .m_busy     (m_busy),
        .m_done     (m_done),
        .m_rdata    (m_rdata),
        .m_nack     (m_nack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // Monitor: compares every command strobe and every done pulse against the queues.
    initial begin
        exp_cmd_t  c;
        exp_done_t d;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (m_start) begin
                    start_cyc = cyc;
                    check("start_vs_busy", 32'(m_busy), 0);
                    if (cmd_q.size() == 0) begin
                        check("unexpected_start", 32'(m_start), 0);
                    end else begin
                        c = cmd_q.pop_front();
                        check("cmd_rw", 32'(m_rw), 32'(c.rw));
                        check("cmd_addr", 32'(m_addr), 32'(c.addr));
                        check("cmd_reg", 32'(m_reg), 32'(c.ptr));
                        check("cmd_wdata", 32'(m_wdata), 32'(c.wdata));
                    end
                end
                if (m_abort) begin
                    abort_cnt++;
                    check("abort_delay", 32'(cyc - start_cyc), TO);
                end
                if (done != '0) begin
                    check("done_onehot", 32'($countones(done)), 1);
                    check("done_one_cycle", 32'(prev_done), 0);
                    check("grant_in_done", 32'(grant), 32'(done));
                    if (done_q.size() == 0) begin
                        check("unexpected_done", 32'(done), 0);
                    end else begin
                        d = done_q.pop_front();
                        check("done_owner", 32'(done), 32'(d.done_vec));
                        check("done_rdata", 32'(rdata), 32'(d.rdata));
                        check("done_err", 32'(err), 32'(d.err));
                    end
                end
            end
            prev_done = done;
        end
    end

    // I2C master model: answers each m_start from resp_q.
    initial begin
        resp_t r;
        int    n;
        forever begin
            @(negedge clk);
            if (m_start && !rst) begin
                r = (resp_q.size() != 0) ? resp_q.pop_front() : '{8'h00, 1'b0, 1, 1'b0, 1'b0};
                if (r.early) begin
                    m_done  = 1'b1;
                    m_rdata = 8'hEE;
                    m_nack  = 1'b1;
                end
                @(posedge clk);
                #1;
                m_done = 1'b0;
                m_busy = 1'b1;
                if (r.hang) begin
                    m_rdata = 8'hFF;
                    n = 0;
                    while (!m_abort && !rst && n < 400) begin
                        @(posedge clk);
                        #1;
                        n++;
                    end
                end else begin
                    repeat (r.delay) @(posedge clk);
                    #1;
                    m_done  = 1'b1;
                    m_rdata = r.rdata;
                    m_nack  = r.nack;
                    @(posedge clk);
                    #1;
                    m_done = 1'b0;
                end
                m_busy  = 1'b0;
                m_rdata = '0;
                m_nack  = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got=stuck want=finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic set_req(input int i, input logic rw, input logic [6:0] addr,
                           input logic [7:0] ptr, input logic [7:0] wdata);
        req_rw[i]          = rw;
        req_addr[7*i +: 7] = addr;
        req_reg[8*i +: 8]  = ptr;
        req_wdata[8*i +: 8] = wdata;
    endtask

    task automatic expect_txn(input int i, input logic rw, input logic [6:0] addr,
                              input logic [7:0] ptr, input logic [7:0] wdata,
                              input logic [7:0] rd, input logic nack, input int delay,
                              input logic early);
        logic [NREQ-1:0] onehot;
        onehot    = '0;
        onehot[i] = 1'b1;
        cmd_q.push_back('{rw, addr, ptr, wdata});
        resp_q.push_back('{rd, nack, delay, early, 1'b0});
        done_q.push_back('{onehot, rd, nack});
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        req    = '0;
        m_busy = 1'b0;
        m_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        done_q.delete();
        cmd_q.delete();
        resp_q.delete();
        rst = 1'b0;
    endtask

    // Acts as the requesters: clears req bits on their done pulse until the scoreboard drains.
    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((done_q.size() != 0 || sched_busy) && n < budget) begin
            @(negedge clk);
            if (!rst) req = req & ~done;
            n++;
        end
        check(name, 32'(done_q.size()), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 32'(grant), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_rdata_err"}, {23'd0, err, rdata}, 0);
        check({tag, "_busy_start_abort"}, {29'd0, sched_busy, m_start, m_abort}, 0);
        check({tag, "_cmd"}, {8'd0, m_rw, m_addr, m_reg, m_wdata}, 0);
    endtask

    initial begin
        int n;
        do_reset();
        check_all_zero("reset");

        // T1: read from requester 0, master busy at first, early spurious m_done.
        m_busy = 1'b1;
        set_req(0, 1'b1, 7'h48, 8'h00, 8'h00);
        expect_txn(0, 1'b1, 7'h48, 8'h00, 8'h00, 8'hA5, 1'b0, 3, 1'b1);
        req[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t1_grant_held", 32'(grant), 32'b0001);
        check("t1_busy", 32'(sched_busy), 1);
        m_busy = 1'b0;
        wait_drain("t1_drain", 100);

        // T2: all four requesting after reset -> served 0,1,2,3.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 1'b1, 7'(8'h10 + i), 8'(8'h20 + i), 8'h00);
            expect_txn(i, 1'b1, 7'(8'h10 + i), 8'(8'h20 + i), 8'h00, 8'(8'h30 + i), 1'b0, 1, 1'b0);
        end
        req = 4'b1111;
        wait_drain("t2_drain", 200);

        // T3: last_grant = 1, then 0110 -> 2 before 1.
        do_reset();
        set_req(1, 1'b0, 7'h21, 8'h01, 8'h11);
        expect_txn(1, 1'b0, 7'h21, 8'h01, 8'h11, 8'h00, 1'b0, 2, 1'b0);
        req[1] = 1'b1;
        wait_drain("t3a_drain", 100);
        set_req(1, 1'b1, 7'h22, 8'h02, 8'h00);
        set_req(2, 1'b1, 7'h33, 8'h03, 8'h00);
        expect_txn(2, 1'b1, 7'h33, 8'h03, 8'h00, 8'h5A, 1'b0, 2, 1'b0);
        expect_txn(1, 1'b1, 7'h22, 8'h02, 8'h00, 8'hC3, 1'b0, 2, 1'b0);
        req = 4'b0110;
        wait_drain("t3b_drain", 200);

        // T4: write with NACK; req dropped right after grant.
        set_req(3, 1'b0, 7'h2A, 8'h10, 8'h5C);
        expect_txn(3, 1'b0, 7'h2A, 8'h10, 8'h5C, 8'h00, 1'b1, 4, 1'b0);
        req[3] = 1'b1;
        n = 0;
        while (!grant[3] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t4_granted", 32'(grant[3]), 1);
        req[3] = 1'b0;
        wait_drain("t4_drain", 100);

        // T5: master never answers.
        set_req(0, 1'b1, 7'h44, 8'h55, 8'h00);
`ifdef I2C_SCHED_TIMEOUT_EN
        cmd_q.push_back('{1'b1, 7'h44, 8'h55, 8'h00});
        resp_q.push_back('{8'h00, 1'b0, 0, 1'b0, 1'b1});
        done_q.push_back('{4'b0001, 8'h00, 1'b1});
        req[0] = 1'b1;
        wait_drain("t5_timeout_drain", 100);
        set_req(0, 1'b1, 7'h66, 8'h77, 8'h00);
`endif
        // T6 (and T5 without watchdog): hang in WAIT, then reset mid-transaction.
        cmd_q.push_back('{1'b1, (`ifdef I2C_SCHED_TIMEOUT_EN 7'h66 `else 7'h44 `endif),
                          (`ifdef I2C_SCHED_TIMEOUT_EN 8'h77 `else 8'h55 `endif), 8'h00});
        resp_q.push_back('{8'h00, 1'b0, 0, 1'b0, 1'b1});
        req[0] = 1'b1;
        n = 0;
        while (!m_busy && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t6_in_wait", 32'(m_busy), 1);
`ifdef I2C_SCHED_TIMEOUT_EN
        repeat (5) @(posedge clk);
`else
        repeat (40) @(posedge clk);
        #1;
        check("t5_stuck_busy", 32'(sched_busy), 1);
        check("t5_no_done", 32'(done_q.size()), 0);
`endif
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("t6_rst");
        req = '0;
        repeat (2) @(posedge clk);
        #1;
        done_q.delete();
        cmd_q.delete();
        resp_q.delete();
        set_req(0, 1'b1, 7'h0A, 8'h0B, 8'h00);
        set_req(3, 1'b0, 7'h3C, 8'h3D, 8'h3E);
        expect_txn(0, 1'b1, 7'h0A, 8'h0B, 8'h00, 8'h81, 1'b0, 1, 1'b0);
        expect_txn(3, 1'b0, 7'h3C, 8'h3D, 8'h3E, 8'h00, 1'b0, 1, 1'b0);
        req = 4'b1001;
        rst = 1'b0;
        wait_drain("t6_drain", 200);

`ifdef I2C_SCHED_TIMEOUT_EN
        check("abort_count", 32'(abort_cnt), 1);
`else
        check("abort_count", 32'(abort_cnt), 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
